// File: rtl/mem_access_sequencer_pkg.sv
// Shared definitions for the memory-access control sequencer: opcode
// constants, the control-step state enum and an opcode legality helper.
package mem_seq_pkg;

  localparam logic [1:0] MEM_LD  = 2'b00;
  localparam logic [1:0] MEM_LDI = 2'b01;
  localparam logic [1:0] MEM_ST  = 2'b10;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    ADDR_Y = 4'd1,
    ADDR_Z = 4'd2,
    ADDR_M = 4'd3,
    LD_RD  = 4'd4,
    LD_WB  = 4'd5,
    ST_MDR = 4'd6,
    ST_WR  = 4'd7,
    FINISH = 4'd8,
    FAULT  = 4'd9
  } seq_state_e;

  // 2'b11 is unassigned; a start carrying it is dropped.
  function automatic logic op_legal(input logic [1:0] op);
    return op != 2'b11;
  endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Control-unit <-> sequencer bundle: start/opcode/mem_ready in, datapath
// control strobes and status out. The sequencer uses the slave side.
interface mem_access_sequencer_if;
  logic       start;
  logic [1:0] opcode;
  logic       mem_ready;
  logic       Grb, BAout, Yin, Cout, alu_add, Zin, Zlowout, MARin;
  logic       Read, Write, MDRin, MDRout, Gra, Rin, Rout;
  logic       busy, done, error;

  modport master (
    output start, opcode, mem_ready,
    input  Grb, BAout, Yin, Cout, alu_add, Zin, Zlowout, MARin,
    input  Read, Write, MDRin, MDRout, Gra, Rin, Rout, busy, done, error
  );

  modport slave (
    input  start, opcode, mem_ready,
    output Grb, BAout, Yin, Cout, alu_add, Zin, Zlowout, MARin,
    output Read, Write, MDRin, MDRout, Gra, Rin, Rout, busy, done, error
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Control-step sequencer for ld/ldi/st. Walks address calculation
// (Rb|0 + C), MAR load and the memory phase; all strobes are Moore outputs
// decoded from the state register, so an async clear drops them at once.
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  clear,
  mem_access_sequencer_if.slave bus
);

  localparam int              CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  seq_state_e    state, state_nxt;
  logic [1:0]    op;
  logic [CW-1:0] count;
  logic          in_wait, expired;

  assign in_wait = (state == LD_RD) || (state == ST_WR);
  assign expired = (count == CNT_LAST);

  // State register and opcode capture on an accepted start.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
      op    <= MEM_LD;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.start && op_legal(bus.opcode))
        op <= bus.opcode;
    end
  end

  // Wait counter: zeroed on entry to a memory wait state, saturates at the last count.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)
      count <= '0;
    else if ((state_nxt == LD_RD || state_nxt == ST_WR) && state_nxt != state)
      count <= '0;
    else if (in_wait && !expired)
      count <= count + 1'b1;
  end

  // Next-state and Moore strobe decode; one bus driver per state.
  always_comb begin
    state_nxt   = state;
    bus.Grb     = 1'b0;
    bus.BAout   = 1'b0;
    bus.Yin     = 1'b0;
    bus.Cout    = 1'b0;
    bus.alu_add = 1'b0;
    bus.Zin     = 1'b0;
    bus.Zlowout = 1'b0;
    bus.MARin   = 1'b0;
    bus.Read    = 1'b0;
    bus.Write   = 1'b0;
    bus.MDRin   = 1'b0;
    bus.MDRout  = 1'b0;
    bus.Gra     = 1'b0;
    bus.Rin     = 1'b0;
    bus.Rout    = 1'b0;
    bus.done    = 1'b0;
    bus.error   = 1'b0;
    bus.busy    = (state != IDLE);
    case (state)
      IDLE: if (bus.start && op_legal(bus.opcode)) state_nxt = ADDR_Y;
      ADDR_Y: begin
        bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
        state_nxt = ADDR_Z;
      end
      ADDR_Z: begin
        bus.Cout = 1'b1; bus.alu_add = 1'b1; bus.Zin = 1'b1;
        state_nxt = ADDR_M;
      end
      ADDR_M: begin
        bus.Zlowout = 1'b1;
        if (op == MEM_LDI) begin
          bus.Gra = 1'b1; bus.Rin = 1'b1;
          state_nxt = FINISH;
        end else begin
          bus.MARin = 1'b1;
          state_nxt = (op == MEM_ST) ? ST_MDR : LD_RD;
        end
      end
      LD_RD: begin
        bus.Read = 1'b1; bus.MDRin = 1'b1;
        // A ready arriving on the expiry cycle still counts as success.
        if (bus.mem_ready)  state_nxt = LD_WB;
        else if (expired)   state_nxt = FAULT;
      end
      LD_WB: begin
        bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        state_nxt = FINISH;
      end
      ST_MDR: begin
        bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
        state_nxt = ST_WR;
      end
      ST_WR: begin
        bus.Write = 1'b1;
        if (bus.mem_ready)  state_nxt = FINISH;
        else if (expired)   state_nxt = FAULT;
      end
      FINISH: begin
        bus.done = 1'b1;
        state_nxt = IDLE;
      end
      FAULT: begin
        bus.error = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer. For each transaction the expected
// per-cycle strobe trace is written out from the instruction's step list,
// then the DUT is driven (with noise on start/opcode/mem_ready where it
// must be ignored) and compared cycle by cycle.
module tb_mem_access_sequencer;
  import mem_seq_pkg::*;

  localparam int T = 4;

  localparam logic [17:0] GRB   = 18'd1 << 17;
  localparam logic [17:0] BAOUT = 18'd1 << 16;
  localparam logic [17:0] YIN   = 18'd1 << 15;
  localparam logic [17:0] COUT  = 18'd1 << 14;
  localparam logic [17:0] ADD   = 18'd1 << 13;
  localparam logic [17:0] ZIN   = 18'd1 << 12;
  localparam logic [17:0] ZLOW  = 18'd1 << 11;
  localparam logic [17:0] MARIN = 18'd1 << 10;
  localparam logic [17:0] READ  = 18'd1 << 9;
  localparam logic [17:0] WRITE = 18'd1 << 8;
  localparam logic [17:0] MDRIN = 18'd1 << 7;
  localparam logic [17:0] MDROUT= 18'd1 << 6;
  localparam logic [17:0] GRA   = 18'd1 << 5;
  localparam logic [17:0] RIN   = 18'd1 << 4;
  localparam logic [17:0] ROUT  = 18'd1 << 3;
  localparam logic [17:0] BUSY  = 18'd1 << 2;
  localparam logic [17:0] DONE  = 18'd1 << 1;
  localparam logic [17:0] ERR   = 18'd1 << 0;

  logic clock, clear;
  mem_access_sequencer_if bus();

  mem_access_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [17:0] expq[$];
  int          rdy_c, q_lo, q_hi;

  function automatic logic [17:0] obs();
    return {bus.Grb, bus.BAout, bus.Yin, bus.Cout, bus.alu_add, bus.Zin,
            bus.Zlowout, bus.MARin, bus.Read, bus.Write, bus.MDRin,
            bus.MDRout, bus.Gra, bus.Rin, bus.Rout, bus.busy, bus.done,
            bus.error};
  endfunction

  task automatic chk(input string tag, input logic [17:0] e);
    logic [17:0] o;
    o = obs();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Expected trace: index c = cycle c after the start cycle (c=0 is IDLE).
  // w = wait cycles before mem_ready; to = memory never answers.
  task automatic build(input logic [1:0] op, input int w, input bit to);
    int n;
    expq = {};
    rdy_c = -1; q_lo = -1; q_hi = -1;
    expq.push_back(18'd0);
    expq.push_back(GRB | BAOUT | YIN | BUSY);
    expq.push_back(COUT | ADD | ZIN | BUSY);
    if (op == MEM_LDI) begin
      expq.push_back(ZLOW | GRA | RIN | BUSY);
      expq.push_back(DONE | BUSY);
    end else begin
      expq.push_back(ZLOW | MARIN | BUSY);
      if (op == MEM_ST) expq.push_back(GRA | ROUT | MDRIN | BUSY);
      q_lo = expq.size();
      n = to ? T : w + 1;
      q_hi = q_lo + n - 1;
      for (int i = 0; i < n; i++)
        expq.push_back(((op == MEM_LD) ? (READ | MDRIN) : WRITE) | BUSY);
      if (!to) rdy_c = q_lo + w;
      if (!to && op == MEM_LD) expq.push_back(MDROUT | GRA | RIN | BUSY);
      expq.push_back((to ? ERR : DONE) | BUSY);
    end
    expq.push_back(18'd0);
  endtask

  // Drive one transaction; if abort_at >= 0, pulse clear mid-cycle once
  // the DUT has been checked in cycle abort_at.
  task automatic run(input string name, input logic [1:0] op, input int w,
                     input bit to, input int abort_at);
    build(op, w, to);
    chk($sformatf("%s idle", name), expq[0]);
    for (int c = 0; c < expq.size() - 1; c++) begin
      if (c == 0) begin
        bus.start  = 1'b1;
        bus.opcode = op;
      end else begin
        bus.start  = ($urandom_range(0, 3) == 0);
        bus.opcode = 2'($urandom_range(0, 3));
      end
      if (c == rdy_c)                 bus.mem_ready = 1'b1;
      else if (c >= q_lo && c <= q_hi) bus.mem_ready = 1'b0;
      else                            bus.mem_ready = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      chk($sformatf("%s op%0d w%0d to%0d c%0d", name, op, w, to, c + 1), expq[c + 1]);
      if (c + 1 == abort_at) begin
        bus.start = 1'b0;
        bus.mem_ready = 1'b0;
        #2 clear = 1'b0;
        #1 chk($sformatf("%s async clear", name), 18'd0);
        @(posedge clock); #1;
        chk($sformatf("%s held clear", name), 18'd0);
        #1 clear = 1'b1;
        @(posedge clock); #1;
        chk($sformatf("%s idle after clear", name), 18'd0);
        break;
      end
    end
    bus.start = 1'b0;
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    int r, w;
    bit to;
    logic [1:0] op;
    clear = 1'b0;
    bus.start = 1'b0;
    bus.opcode = 2'b00;
    bus.mem_ready = 1'b0;
    #12;
    chk("reset", 18'd0);
    @(negedge clock) clear = 1'b1;
    @(posedge clock); #1;
    chk("post reset idle", 18'd0);

    run("ldi", MEM_LDI, 0, 1'b0, -1);
    run("ld_w3", MEM_LD, 3, 1'b0, -1);
    run("st_w0", MEM_ST, 0, 1'b0, -1);
    run("ld_timeout", MEM_LD, 0, 1'b1, -1);
    run("st_timeout", MEM_ST, 0, 1'b1, -1);
    // ST_WR begins at cycle 5 of an ST sequence.
    run("st_clear", MEM_ST, 0, 1'b1, 5);
    run("ld_after_clear", MEM_LD, 1, 1'b0, -1);

    // Illegal opcode in IDLE: nothing starts.
    bus.start = 1'b1;
    bus.opcode = 2'b11;
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      chk($sformatf("illegal op c%0d", i), 18'd0);
    end
    bus.start = 1'b0;
    bus.mem_ready = 1'b0;
    run("after_illegal", MEM_LDI, 0, 1'b0, -1);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 2);
      op = (r == 0) ? MEM_LD : (r == 1) ? MEM_LDI : MEM_ST;
      w = $urandom_range(0, T - 1);
      to = ($urandom_range(0, 3) == 0);
      run($sformatf("rnd%0d", k), op, w, to, -1);
      // Occasional idle gap with ready noise, which must be ignored.
      if ($urandom_range(0, 1) == 1) begin
        bus.mem_ready = 1'b1;
        @(posedge clock); #1;
        chk($sformatf("rnd%0d gap", k), 18'd0);
        bus.mem_ready = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
